// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: owns the program counter, issues single-outstanding imem fetches, and buffers one instruction.
// Optional macro PC_MISALIGN_TRAP_EN: misaligned non-trap redirect targets divert to mtvec and pulse misalign_err.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_sel,
    input  logic [31:0] jal,
    input  logic [31:0] jalr,
    input  logic [31:0] branch,
    input  logic [31:0] mtvec,
    input  logic        stall,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ready,
    input  logic        fetch_rvalid,
    input  logic [31:0] fetch_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misalign_err
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        FLUSH,
        BUF
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic [31:0] r_inflight_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_instr_valid;
    logic [31:0] w_tgt_raw;
    logic [31:0] w_tgt;
    logic        w_accept;
    logic        w_capture;
    logic        w_drop;

    always_comb begin
        w_tgt_raw = jal;
        case (redirect_sel)
            2'd0:    w_tgt_raw = jal;
            2'd1:    w_tgt_raw = {jalr[31:1], 1'b0};
            2'd2:    w_tgt_raw = branch;
            default: w_tgt_raw = mtvec;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_misalign;

    // A halfword-aligned target from jal/jalr/branch diverts the PC to the trap vector.
    assign w_misalign   = redirect_valid && (redirect_sel != 2'd3) && w_tgt_raw[1];
    assign w_tgt        = w_misalign ? mtvec : w_tgt_raw;
    assign misalign_err = r_misalign;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign;
        end
    end
`else
    assign w_tgt        = {w_tgt_raw[31:2], 2'b00};
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            IDLE: begin
                w_next_state = REQ;
                if (redirect_valid) begin
                    w_next_pc = w_tgt;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    w_next_pc    = w_tgt;
                    w_next_state = fetch_ready ? FLUSH : REQ;
                end else if (fetch_ready) begin
                    w_accept     = 1'b1;
                    w_next_pc    = r_pc + 32'd4;
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    w_next_pc    = w_tgt;
                    w_next_state = fetch_rvalid ? REQ : FLUSH;
                end else if (fetch_rvalid) begin
                    w_capture    = 1'b1;
                    w_next_state = BUF;
                end
            end
            FLUSH: begin
                // A stale response arriving alongside a fresh redirect still retires the outstanding fetch.
                if (redirect_valid) begin
                    w_next_pc = w_tgt;
                end
                if (fetch_rvalid) begin
                    w_next_state = REQ;
                end
            end
            BUF: begin
                if (redirect_valid) begin
                    w_next_pc    = w_tgt;
                    w_drop       = 1'b1;
                    w_next_state = REQ;
                end else if (!stall) begin
                    w_drop       = 1'b1;
                    w_next_state = REQ;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= IDLE;
            r_pc          <= RESET_VEC;
            r_inflight_pc <= RESET_VEC;
            r_instr       <= 32'd0;
            r_instr_pc    <= 32'd0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (w_accept) begin
                r_inflight_pc <= r_pc;
            end
            if (w_capture) begin
                r_instr       <= fetch_rdata;
                r_instr_pc    <= r_inflight_pc;
                r_instr_valid <= 1'b1;
            end else if (w_drop) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign fetch_req   = (r_state == REQ);
    assign fetch_addr  = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; a second instance exercises the wrapping reset vector.
// Honours PC_MISALIGN_TRAP_EN to pick the expected misaligned-jalr behaviour.
module tb_pc_sequencer;

    logic        CLK;
    logic        RST_N;
    logic        rst2N;
    logic        redirect_valid;
    logic [1:0]  redirect_sel;
    logic [31:0] jal;
    logic [31:0] jalr;
    logic [31:0] branch;
    logic [31:0] mtvec;
    logic        stall;
    logic        fetch_ready;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;

    logic        fetchReq;
    logic [31:0] fetchAddr;
    logic        instrValid;
    logic [31:0] instrWord;
    logic [31:0] instrPc;
    logic        misalignErr;

    logic        fetchReq2;
    logic [31:0] fetchAddr2;
    logic        instrValid2;
    logic [31:0] instrWord2;
    logic [31:0] instrPc2;
    logic        misalignErr2;

    int total;
    int bad;

    pc_sequencer dut (
        .CLK(CLK), .RST_N(RST_N),
        .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
        .jal(jal), .jalr(jalr), .branch(branch), .mtvec(mtvec),
        .stall(stall),
        .fetch_req(fetchReq), .fetch_addr(fetchAddr),
        .fetch_ready(fetch_ready), .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .instr_valid(instrValid), .instr(instrWord), .instr_pc(instrPc),
        .misalign_err(misalignErr)
    );

    pc_sequencer #(.RESET_VEC(32'hFFFF_FFFC)) dutWrap (
        .CLK(CLK), .RST_N(rst2N),
        .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
        .jal(jal), .jalr(jalr), .branch(branch), .mtvec(mtvec),
        .stall(stall),
        .fetch_req(fetchReq2), .fetch_addr(fetchAddr2),
        .fetch_ready(fetch_ready), .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .instr_valid(instrValid2), .instr(instrWord2), .instr_pc(instrPc2),
        .misalign_err(misalignErr2)
    );

    // Free-running clock; inputs change and outputs are sampled on the falling edge.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [1:0] sel, input logic rdy,
                                 input logic rval, input logic [31:0] rdata, input logic stl);
        redirect_valid = rv;
        redirect_sel   = sel;
        fetch_ready    = rdy;
        fetch_rvalid   = rval;
        fetch_rdata    = rdata;
        stall          = stl;
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic checkFetch(input string tag, input logic req, input logic [31:0] addr, input logic vld);
        checkOutput({tag, ".req"}, {31'd0, fetchReq}, {31'd0, req});
        checkOutput({tag, ".addr"}, fetchAddr, addr);
        checkOutput({tag, ".valid"}, {31'd0, instrValid}, {31'd0, vld});
    endtask

    task automatic checkInstr(input string tag, input logic [31:0] word, input logic [31:0] pc);
        checkOutput({tag, ".instr"}, instrWord, word);
        checkOutput({tag, ".pc"}, instrPc, pc);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST_N = 1'b0;
        rst2N = 1'b0;
        jal    = 32'h0;
        jalr   = 32'h0;
        branch = 32'h0;
        mtvec  = 32'h0;
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 32'h11, 1'b0);
        tick();
        tick();

        // Reset state
        checkFetch("rst", 1'b0, 32'h0, 1'b0);
        checkInstr("rst", 32'h0, 32'h0);
        checkOutput("rst.mis", {31'd0, misalignErr}, 32'h0);
        RST_N = 1'b1;

        // Sequential fetch 0x0, 0x4, 0x8 with zero-wait imem
        tick();
        checkFetch("seq0.req", 1'b1, 32'h0, 1'b0);
        tick();
        checkFetch("seq0.wait", 1'b0, 32'h4, 1'b0);
        tick();
        checkFetch("seq0.buf", 1'b0, 32'h4, 1'b1);
        checkInstr("seq0.buf", 32'h11, 32'h0);
        fetch_rdata = 32'h22;
        tick();
        checkFetch("seq1.req", 1'b1, 32'h4, 1'b0);
        tick();
        tick();
        checkFetch("seq1.buf", 1'b0, 32'h8, 1'b1);
        checkInstr("seq1.buf", 32'h22, 32'h4);
        tick();
        checkFetch("seq2.req", 1'b1, 32'h8, 1'b0);

        // jal redirect coinciding with the response in WAIT drops that response
        tick();
        jal = 32'h100;
        applyStimulus(1'b1, 2'd0, 1'b1, 1'b1, 32'h33, 1'b0);
        tick();
        checkFetch("jal.req", 1'b1, 32'h100, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 32'h44, 1'b0);
        tick();
        tick();
        checkFetch("jal.buf", 1'b0, 32'h104, 1'b1);
        checkInstr("jal.buf", 32'h44, 32'h100);
        tick();
        checkFetch("jal.next", 1'b1, 32'h104, 1'b0);

        // branch redirect in WAIT with a late response goes through FLUSH
        fetch_rvalid = 1'b0;
        tick();
        branch = 32'h40;
        applyStimulus(1'b1, 2'd2, 1'b1, 1'b0, 32'h55, 1'b0);
        tick();
        checkFetch("br.flush", 1'b0, 32'h40, 1'b0);
        redirect_valid = 1'b0;
        tick();
        tick();
        checkFetch("br.flush2", 1'b0, 32'h40, 1'b0);
        fetch_rvalid = 1'b1;
        tick();
        checkFetch("br.req", 1'b1, 32'h40, 1'b0);

        // Stall holds the buffered instruction for five cycles
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 32'h0050_0093, 1'b1);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checkFetch($sformatf("stall%0d", i), 1'b0, 32'h44, 1'b1);
            checkInstr($sformatf("stall%0d", i), 32'h0050_0093, 32'h40);
            if (i < 4) tick();
        end
        stall = 1'b0;
        tick();
        checkFetch("stall.rel", 1'b1, 32'h44, 1'b0);

        // jalr redirects while the request is withdrawn
        jalr  = 32'h205;
        mtvec = 32'h80;
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        checkFetch("jalr205", 1'b1, 32'h204, 1'b0);
        checkOutput("jalr205.mis", {31'd0, misalignErr}, 32'h0);
        jalr = 32'h206;
        tick();
`ifdef PC_MISALIGN_TRAP_EN
        checkFetch("jalr206", 1'b1, 32'h80, 1'b0);
        checkOutput("jalr206.mis", {31'd0, misalignErr}, 32'h1);
`else
        checkFetch("jalr206", 1'b1, 32'h204, 1'b0);
        checkOutput("jalr206.mis", {31'd0, misalignErr}, 32'h0);
`endif
        redirect_valid = 1'b0;
        tick();
        checkOutput("jalr.mis.end", {31'd0, misalignErr}, 32'h0);

        // Trap redirect on an accepted request flushes it
        mtvec = 32'h300;
        applyStimulus(1'b1, 2'd3, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        checkFetch("trap.flush", 1'b0, 32'h300, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 32'h99, 1'b0);
        tick();
        checkFetch("trap.req", 1'b1, 32'h300, 1'b0);

        // Wrapping reset vector and asynchronous reset during WAIT
        RST_N = 1'b0;
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 32'h66, 1'b0);
        rst2N = 1'b1;
        tick();
        checkOutput("wrap.addr0", fetchAddr2, 32'hFFFF_FFFC);
        checkOutput("wrap.req0", {31'd0, fetchReq2}, 32'h1);
        tick();
        tick();
        checkOutput("wrap.bufpc", instrPc2, 32'hFFFF_FFFC);
        checkOutput("wrap.bufins", instrWord2, 32'h66);
        tick();
        checkOutput("wrap.addr1", fetchAddr2, 32'h0);
        checkOutput("wrap.req1", {31'd0, fetchReq2}, 32'h1);
        fetch_rvalid = 1'b0;
        tick();
        rst2N = 1'b0;
        #1;
        checkOutput("arst.addr", fetchAddr2, 32'hFFFF_FFFC);
        checkOutput("arst.valid", {31'd0, instrValid2}, 32'h0);
        checkOutput("arst.instr", instrWord2, 32'h0);
        checkOutput("arst.pc", instrPc2, 32'h0);
        checkOutput("arst.req", {31'd0, fetchReq2}, 32'h0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 32'h77, 1'b0);
        tick();
        rst2N = 1'b1;
        tick();
        checkOutput("late.req", {31'd0, fetchReq2}, 32'h1);
        checkOutput("late.addr", fetchAddr2, 32'hFFFF_FFFC);
        checkOutput("late.valid", {31'd0, instrValid2}, 32'h0);
        tick();
        checkOutput("late.wait", {31'd0, instrValid2}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
